line_burst_sched: RTL and testbench
===================================

// Module: line_burst_sched
// PURPOSE
//  Per-line burst scheduler for the VDMA read/write engines; sits directly upstream of the frame address generator.
//  Splits each video line into full AXI bursts plus one tail burst and drives new_base/burst_req/tail_req to it.
//  The address stage advances on the falling edges of those requests, so this block owns the request timing and gaps.
// PARAMETERS
//  BURST_LEN      64     beats per full burst; power of two, 2..256
//  LSIZE          16     width of line_beats
//  TIMEOUT_CYCLES 4096   watchdog limit per request; used only with BURST_TIMEOUT_EN
// PORTS
//  clock        in   1      single clock
//  rst_n        in   1      asynchronous, active-low reset
//  frame_start  in   1      1-cycle pulse, start of frame
//  line_start   in   1      1-cycle pulse, line data available
//  line_beats   in   LSIZE  beats in the line; sampled on line acceptance
//  fifo_ok      in   1      room/data for one burst; gates every request start
//  xfer_done    in   1      1-cycle pulse: current AXI transaction complete
//  new_base     out  1      1-cycle pulse to address stage
//  burst_req    out  1      full-burst request, level
//  tail_req     out  1      tail/line-advance request, level
//  req_len      out  8      AXI LEN (beats-1) of the active request
//  tail_valid   out  1      tail_req carries a real transaction (tail beats > 0)
//  line_done    out  1      1-cycle pulse, line finished
//  line_ovf     out  1      sticky: line_start lost; cleared by frame acceptance
//  timeout_err  out  1      sticky watchdog flag (0 when feature compiled out)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0, pending flags 0.
//  Reset is asynchronous at any point, mid-burst included; the request drops immediately and nothing resumes.
//  States: IDLE, ARM, FULL, TAIL, GAP, DONE.
//  - Frame acceptance: a frame_start seen in IDLE/ARM pulses new_base on the next cycle.
//    The same acceptance clears line_ovf and any pending line.
//  - Frame_start while a line is in progress is held pending; it is served in DONE, before any pending line.
//  - line_start seen in IDLE/ARM: latch line_beats and go to ARM.
//    nfull = line_beats >> log2(BURST_LEN); ntail = line_beats & (BURST_LEN-1).
//  - line_start while busy sets a 1-deep pending line. A second one while pending sets line_ovf and is dropped.
//  - ARM: wait fifo_ok=1. If nfull>0, go to FULL; otherwise go to TAIL.
//  - FULL: burst_req=1, req_len=BURST_LEN-1. On xfer_done, burst_req drops the next cycle, nfull decrements, go to GAP.
//  - GAP: requests held low for exactly 2 cycles, so the address stage's edge detector settles.
//    Then return to FULL (nfull>0, fifo_ok=1) or TAIL (nfull=0). While fifo_ok=0, stay low.
//  - TAIL, ntail>0: tail_req=1, tail_valid=1, req_len=ntail-1, held until xfer_done.
//  - TAIL, ntail=0: tail_req=1 for exactly 1 cycle, tail_valid=0, req_len=0, xfer_done not awaited.
//    This advances the line address without an AXI transaction.
//  - After tail_req falls: 2-cycle GAP, then DONE. DONE pulses line_done for 1 cycle.
//    DONE then serves pending frame, then pending line, else goes to IDLE.
//  - line_beats=0: tail strobe only (ntail=0 path), then line_done.
//  - frame_start and line_start in the same IDLE cycle: new_base pulses first.
//    The line is accepted, and its first request rises no earlier than 2 cycles after new_base.
//  - xfer_done while no request is active is ignored.
//  - burst_req and tail_req are never high together.
//  - Minimum of 2 low cycles between any request fall and the next rise.
// CONFIGURATION
//  BURST_TIMEOUT_EN defined: a counter runs while burst_req or tail_req is high and resets on every new request.
//    At TIMEOUT_CYCLES without xfer_done, the request drops and timeout_err sets (sticky until reset).
//    The FSM then goes to GAP and continues as if done.
//  BURST_TIMEOUT_EN undefined: no counter; requests wait indefinitely; timeout_err tied 0.
// TESTING
//  BURST_LEN=64, line_beats=200 -> 3 burst_req (req_len=63), then tail_req req_len=7, tail_valid=1; one line_done.
//  line_beats=128 -> 2 burst_req, then 1-cycle tail_req with tail_valid=0; line_done 3 cycles after tail falls.
//  line_beats=0 -> only the tail strobe, then line_done; zero burst_req.
//  frame_start+line_start same cycle -> new_base at T+1, first burst_req rise >= T+3.
//  fifo_ok=0 for 10 cycles in GAP -> no request until fifo_ok=1.
//  Two extra line_start during a line -> second sets line_ovf.
//  rst_n low mid-burst -> all outputs 0 asynchronously.
//  BURST_TIMEOUT_EN, TIMEOUT_CYCLES=16, no xfer_done -> req falls after 16 cycles, timeout_err=1, line completes.

Source files
------------

// File: rtl/line_burst_sched.sv
// line_burst_sched: per-line burst scheduler ahead of the frame address generator.
// Splits each line into full bursts plus one tail request and owns request timing and the
// low gaps between requests. The address stage advances on request falling edges.
// Optional watchdog: define BURST_TIMEOUT_EN to bound every request to TIMEOUT_CYCLES.
module line_burst_sched #(
  parameter int unsigned BURST_LEN      = 64,
  parameter int unsigned LSIZE          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             line_start,
  input  logic [LSIZE-1:0] line_beats,
  input  logic             fifo_ok,
  input  logic             xfer_done,
  output logic             new_base,
  output logic             burst_req,
  output logic             tail_req,
  output logic [7:0]       req_len,
  output logic             tail_valid,
  output logic             line_done,
  output logic             line_ovf,
  output logic             timeout_err
);

  localparam int unsigned LB       = $clog2(BURST_LEN);
  localparam logic [7:0]  FULL_LEN = 8'(BURST_LEN - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARM  = 3'd1;
  localparam logic [2:0] S_FULL = 3'd2;
  localparam logic [2:0] S_TAIL = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]       state, state_d;
  logic [LSIZE-1:0] nfull, nfull_d;
  logic [LB-1:0]    ntail, ntail_d;
  logic             gap_wait, gap_wait_d;
  logic             tail_phase, tail_phase_d;
  logic             pend_frame, pend_frame_d;
  logic             pend_line, pend_line_d;
  logic [LSIZE-1:0] pend_beats, pend_beats_d;

  logic             new_base_d, burst_req_d, tail_req_d, tail_valid_d, line_done_d, line_ovf_d;
  logic [7:0]       req_len_d;

  logic             take_line;
  logic [LSIZE-1:0] take_beats;
  logic             start_full, start_tail;
  logic             tmo_hit;

`ifdef BURST_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt, tmo_cnt_d;
  logic          timeout_err_d;
  logic          tmo_fire;

  // Watchdog reaches its limit on the last allowed high cycle of a request.
  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  // Watchdog absent: requests wait indefinitely; parameter kept referenced for a uniform interface.
  assign tmo_hit     = (TIMEOUT_CYCLES == 0) && 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Next-state, counter, pending-flag and registered-output decode.
  always_comb begin
    state_d      = state;
    nfull_d      = nfull;
    ntail_d      = ntail;
    gap_wait_d   = gap_wait;
    tail_phase_d = tail_phase;
    pend_frame_d = pend_frame;
    pend_line_d  = pend_line;
    pend_beats_d = pend_beats;
    line_ovf_d   = line_ovf;
    new_base_d   = 1'b0;
    burst_req_d  = 1'b0;
    tail_req_d   = 1'b0;
    tail_valid_d = 1'b0;
    req_len_d    = 8'd0;
    line_done_d  = 1'b0;
    take_line    = 1'b0;
    take_beats   = '0;
    start_full   = 1'b0;
    start_tail   = 1'b0;

    case (state)
      S_IDLE, S_ARM: begin
        if (frame_start || pend_frame) begin
          new_base_d   = 1'b1;
          line_ovf_d   = 1'b0;
          pend_frame_d = 1'b0;
          if (frame_start) pend_line_d = 1'b0;
        end
        if (line_start) begin
          take_line  = 1'b1;
          take_beats = line_beats;
          if (pend_line_d) begin
            line_ovf_d  = 1'b1;
            pend_line_d = 1'b0;
          end
        end else if (pend_line_d) begin
          take_line   = 1'b1;
          take_beats  = pend_beats;
          pend_line_d = 1'b0;
        end
        // A fresh new_base blocks request start so the first rise trails it by two cycles.
        if (take_line) begin
          state_d = S_ARM;
        end else if ((state == S_ARM) && fifo_ok && !new_base && !new_base_d) begin
          if (nfull != '0) start_full = 1'b1;
          else             start_tail = 1'b1;
        end
      end

      S_FULL: begin
        if (xfer_done || tmo_hit) begin
          nfull_d    = nfull - LSIZE'(1);
          gap_wait_d = 1'b0;
          state_d    = S_GAP;
        end else begin
          burst_req_d = 1'b1;
          req_len_d   = FULL_LEN;
        end
      end

      S_TAIL: begin
        // Zero-beat tail is a single-cycle strobe that never waits for xfer_done.
        if ((ntail == '0) || xfer_done || tmo_hit) begin
          tail_phase_d = 1'b1;
          gap_wait_d   = 1'b0;
          state_d      = S_GAP;
        end else begin
          tail_req_d   = 1'b1;
          tail_valid_d = 1'b1;
          req_len_d    = 8'(ntail) - 8'd1;
        end
      end

      S_GAP: begin
        if (!gap_wait) begin
          gap_wait_d = 1'b1;
        end else if (tail_phase) begin
          state_d = S_DONE;
        end else if (fifo_ok) begin
          if (nfull != '0) start_full = 1'b1;
          else             start_tail = 1'b1;
        end
      end

      S_DONE: begin
        line_done_d  = 1'b1;
        tail_phase_d = 1'b0;
        if (pend_frame) begin
          new_base_d   = 1'b1;
          line_ovf_d   = 1'b0;
          pend_frame_d = 1'b0;
        end
        if (pend_line) begin
          take_line   = 1'b1;
          take_beats  = pend_beats;
          pend_line_d = 1'b0;
          state_d     = S_ARM;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (take_line) begin
      nfull_d = take_beats >> LB;
      ntail_d = take_beats[LB-1:0];
    end

    if (start_full) begin
      state_d     = S_FULL;
      burst_req_d = 1'b1;
      req_len_d   = FULL_LEN;
    end

    if (start_tail) begin
      state_d      = S_TAIL;
      tail_req_d   = 1'b1;
      tail_valid_d = (ntail != '0);
      req_len_d    = (ntail != '0) ? (8'(ntail) - 8'd1) : 8'd0;
    end

    // While a line is in flight, frames and lines are parked; a second parked line is lost.
    if ((state != S_IDLE) && (state != S_ARM)) begin
      if (frame_start) pend_frame_d = 1'b1;
      if (line_start) begin
        if (pend_line_d) begin
          line_ovf_d = 1'b1;
        end else begin
          pend_line_d  = 1'b1;
          pend_beats_d = line_beats;
        end
      end
    end

`ifdef BURST_TIMEOUT_EN
    tmo_fire = tmo_hit && !xfer_done &&
               ((state == S_FULL) || ((state == S_TAIL) && (ntail != '0)));
    timeout_err_d = timeout_err | tmo_fire;
    if (start_full || start_tail)                  tmo_cnt_d = '0;
    else if ((state_d == S_FULL) || (state_d == S_TAIL)) tmo_cnt_d = tmo_cnt + TW'(1);
    else                                           tmo_cnt_d = '0;
`endif
  end

  // State, counters and registered outputs; reset drops every request immediately.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      nfull      <= '0;
      ntail      <= '0;
      gap_wait   <= 1'b0;
      tail_phase <= 1'b0;
      pend_frame <= 1'b0;
      pend_line  <= 1'b0;
      pend_beats <= '0;
      new_base   <= 1'b0;
      burst_req  <= 1'b0;
      tail_req   <= 1'b0;
      tail_valid <= 1'b0;
      req_len    <= 8'd0;
      line_done  <= 1'b0;
      line_ovf   <= 1'b0;
`ifdef BURST_TIMEOUT_EN
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      nfull      <= nfull_d;
      ntail      <= ntail_d;
      gap_wait   <= gap_wait_d;
      tail_phase <= tail_phase_d;
      pend_frame <= pend_frame_d;
      pend_line  <= pend_line_d;
      pend_beats <= pend_beats_d;
      new_base   <= new_base_d;
      burst_req  <= burst_req_d;
      tail_req   <= tail_req_d;
      tail_valid <= tail_valid_d;
      req_len    <= req_len_d;
      line_done  <= line_done_d;
      line_ovf   <= line_ovf_d;
`ifdef BURST_TIMEOUT_EN
      tmo_cnt     <= tmo_cnt_d;
      timeout_err <= timeout_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_line_burst_sched.sv
// Directed bench for line_burst_sched (BURST_LEN=64). A monitor tallies request edges, lengths
// and timing; a responder acknowledges real transactions after three high cycles.
module tb_line_burst_sched;

`ifdef BURST_TIMEOUT_EN
  localparam int unsigned TMO = 16;
`else
  localparam int unsigned TMO = 4096;
`endif

  logic        clock;
  logic        rst_n;
  logic        frame_start;
  logic        line_start;
  logic [15:0] line_beats;
  logic        fifo_ok;
  logic        xfer_done;
  logic        new_base;
  logic        burst_req;
  logic        tail_req;
  logic [7:0]  req_len;
  logic        tail_valid;
  logic        line_done;
  logic        line_ovf;
  logic        timeout_err;

  line_burst_sched #(
    .BURST_LEN      (64),
    .LSIZE          (16),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .line_start  (line_start),
    .line_beats  (line_beats),
    .fifo_ok     (fifo_ok),
    .xfer_done   (xfer_done),
    .new_base    (new_base),
    .burst_req   (burst_req),
    .tail_req    (tail_req),
    .req_len     (req_len),
    .tail_valid  (tail_valid),
    .line_done   (line_done),
    .line_ovf    (line_ovf),
    .timeout_err (timeout_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Monitor: edge counts, lengths at rise, high durations and event cycle stamps.
  int cyc = 0, burst_rises = 0, tail_rises = 0, done_cnt = 0, nb_cnt = 0;
  int last_burst_len = 0, last_tail_len = 0, last_tail_valid = 0;
  int bhi = 0, thi = 0, last_bhi = 0, last_thi = 0;
  int tail_fall_cyc = 0, done_cyc = 0, nb_cyc = 0, nb_to_req = -1;
  int overlap = 0, gap_viol = 0, low_run = 100;
  bit p_burst = 1'b0, p_tail = 1'b0, seen_fall = 1'b0, nb_armed = 1'b0;

  always @(negedge clock) begin
    cyc++;
    if (burst_req && tail_req) overlap++;
    if ((burst_req && !p_burst) || (tail_req && !p_tail)) begin
      if (seen_fall && low_run < 2) gap_viol++;
      if (nb_armed) begin
        nb_to_req = cyc - nb_cyc;
        nb_armed  = 1'b0;
      end
    end
    if (burst_req && !p_burst) begin
      burst_rises++;
      last_burst_len = int'(req_len);
    end
    if (tail_req && !p_tail) begin
      tail_rises++;
      last_tail_len   = int'(req_len);
      last_tail_valid = int'(tail_valid);
    end
    if (burst_req) bhi = p_burst ? bhi + 1 : 1;
    if (tail_req)  thi = p_tail ? thi + 1 : 1;
    if (!burst_req && p_burst) begin
      last_bhi  = bhi;
      seen_fall = 1'b1;
    end
    if (!tail_req && p_tail) begin
      last_thi      = thi;
      tail_fall_cyc = cyc;
      seen_fall     = 1'b1;
    end
    if (burst_req || tail_req) low_run = 0;
    else                       low_run++;
    if (line_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (new_base) begin
      nb_cnt++;
      nb_cyc   = cyc;
      nb_armed = 1'b1;
    end
    p_burst = burst_req;
    p_tail  = tail_req;
  end

  // Responder: pulses xfer_done on the third high cycle of a real transaction.
  bit ack_en = 1'b1;
  int hcnt   = 0;
  initial begin
    xfer_done = 1'b0;
    forever begin
      @(negedge clock);
      if (xfer_done) begin
        xfer_done = 1'b0;
        hcnt      = 0;
      end else if (ack_en && (burst_req || (tail_req && tail_valid))) begin
        hcnt++;
        if (hcnt >= 3) xfer_done = 1'b1;
      end else begin
        hcnt = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_line(input logic [15:0] beats, input logic with_frame);
    line_start  = 1'b1;
    line_beats  = beats;
    frame_start = with_frame;
    @(negedge clock);
    line_start  = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input int target, input string tag);
    for (int i = 0; i < 3000 && done_cnt < target; i++) @(negedge clock);
    check(tag, 32'(done_cnt >= target), 32'd1);
    tick(2);
  endtask

  int b0, t0, d0, n0;

  initial begin
    rst_n       = 1'b0;
    frame_start = 1'b0;
    line_start  = 1'b0;
    line_beats  = 16'd0;
    fifo_ok     = 1'b1;
    tick(3);
    check("rst_flags", 32'({new_base, burst_req, tail_req, tail_valid, line_done, line_ovf, timeout_err}), 32'd0);
    check("rst_req_len", 32'(req_len), 32'd0);
    rst_n = 1'b1;
    tick(3);
    check("idle_flags", 32'({new_base, burst_req, tail_req, tail_valid, line_done, line_ovf, timeout_err}), 32'd0);

    // Frame and 200-beat line in the same cycle: 3 full bursts plus an 8-beat tail.
    b0 = burst_rises; t0 = tail_rises; d0 = done_cnt; n0 = nb_cnt;
    pulse_line(16'd200, 1'b1);
    wait_done(d0 + 1, "a_done_wait");
    check("a_new_base_cnt", 32'(nb_cnt - n0), 32'd1);
    check("a_nb_to_req_ge2", 32'(nb_to_req >= 2), 32'd1);
    check("a_bursts", 32'(burst_rises - b0), 32'd3);
    check("a_burst_len", 32'(last_burst_len), 32'd63);
    check("a_tails", 32'(tail_rises - t0), 32'd1);
    check("a_tail_len", 32'(last_tail_len), 32'd7);
    check("a_tail_valid", 32'(last_tail_valid), 32'd1);
    check("a_line_done_cnt", 32'(done_cnt - d0), 32'd1);

    // 128 beats: 2 bursts then a one-cycle zero-beat tail strobe.
    b0 = burst_rises; t0 = tail_rises; d0 = done_cnt;
    pulse_line(16'd128, 1'b0);
    wait_done(d0 + 1, "b_done_wait");
    check("b_bursts", 32'(burst_rises - b0), 32'd2);
    check("b_tails", 32'(tail_rises - t0), 32'd1);
    check("b_tail_valid", 32'(last_tail_valid), 32'd0);
    check("b_tail_len", 32'(last_tail_len), 32'd0);
    check("b_tail_high_cycles", 32'(last_thi), 32'd1);
    check("b_done_after_fall", 32'(done_cyc - tail_fall_cyc), 32'd3);

    // Empty line: tail strobe only.
    b0 = burst_rises; t0 = tail_rises; d0 = done_cnt;
    pulse_line(16'd0, 1'b0);
    wait_done(d0 + 1, "c_done_wait");
    check("c_bursts", 32'(burst_rises - b0), 32'd0);
    check("c_tails", 32'(tail_rises - t0), 32'd1);
    check("c_tail_valid", 32'(last_tail_valid), 32'd0);
    check("c_line_done_cnt", 32'(done_cnt - d0), 32'd1);

    // fifo_ok low across the gap holds off the next burst.
    b0 = burst_rises; d0 = done_cnt;
    pulse_line(16'd200, 1'b0);
    for (int i = 0; i < 50 && burst_rises == b0; i++) @(negedge clock);
    fifo_ok = 1'b0;
    tick(12);
    check("d_stalled_bursts", 32'(burst_rises - b0), 32'd1);
    check("d_stalled_reqs", 32'({burst_req, tail_req}), 32'd0);
    fifo_ok = 1'b1;
    wait_done(d0 + 1, "d_done_wait");
    check("d_bursts", 32'(burst_rises - b0), 32'd3);

    // Two extra line_starts while busy: first parks, second overflows.
    b0 = burst_rises; t0 = tail_rises; d0 = done_cnt; n0 = nb_cnt;
    pulse_line(16'd200, 1'b0);
    tick(3);
    pulse_line(16'd64, 1'b0);
    tick(1);
    check("e_ovf_after_one", 32'(line_ovf), 32'd0);
    pulse_line(16'd10, 1'b0);
    tick(1);
    check("e_ovf_after_two", 32'(line_ovf), 32'd1);
    wait_done(d0 + 2, "e_done_wait");
    check("e_bursts", 32'(burst_rises - b0), 32'd4);
    check("e_tails", 32'(tail_rises - t0), 32'd2);
    check("e_last_tail_valid", 32'(last_tail_valid), 32'd0);
    check("e_ovf_sticky", 32'(line_ovf), 32'd1);
    frame_start = 1'b1;
    @(negedge clock);
    frame_start = 1'b0;
    tick(2);
    check("e_ovf_cleared", 32'(line_ovf), 32'd0);
    check("e_new_base_cnt", 32'(nb_cnt - n0), 32'd1);

`ifdef BURST_TIMEOUT_EN
    // No acknowledgements: every request times out after 16 cycles and the line still completes.
    ack_en = 1'b0;
    b0 = burst_rises; t0 = tail_rises; d0 = done_cnt;
    pulse_line(16'd200, 1'b0);
    wait_done(d0 + 1, "t_done_wait");
    check("t_bursts", 32'(burst_rises - b0), 32'd3);
    check("t_burst_high", 32'(last_bhi), 32'd16);
    check("t_tail_high", 32'(last_thi), 32'd16);
    check("t_timeout_err", 32'(timeout_err), 32'd1);
    ack_en = 1'b1;
`endif

    // Asynchronous reset mid-burst: outputs clear before the next clock edge, nothing resumes.
    b0 = burst_rises; d0 = done_cnt;
    pulse_line(16'd200, 1'b0);
    for (int i = 0; i < 50 && !burst_req; i++) @(negedge clock);
    check("g_burst_up", 32'(burst_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("g_async_flags", 32'({new_base, burst_req, tail_req, tail_valid, line_done, line_ovf, timeout_err}), 32'd0);
    check("g_async_len", 32'(req_len), 32'd0);
    @(negedge clock);
    rst_n = 1'b1;
    tick(20);
    check("g_no_resume", 32'({burst_req, tail_req}), 32'd0);
    check("g_no_done", 32'(done_cnt - d0), 32'd0);

    check("never_overlap", 32'(overlap), 32'd0);
    check("min_gap", 32'(gap_viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
